// File: rtl/control_input_decoder_pkg.sv
// control_input_decoder_pkg: speed limits shared with speed_controller and pause FSM encoding
package control_input_decoder_pkg;

    localparam logic [2:0] SPEED_MIN     = 3'd1;
    localparam logic [2:0] SPEED_MAX     = 3'd6;
    localparam logic [2:0] SPEED_DEFAULT = 3'd3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } pause_state_e;

    // Opposing requests in the same cycle cancel; otherwise step and clamp.
    function automatic logic [2:0] next_level(input logic [2:0] lvl, input logic inc, input logic dec);
        return (inc && !dec && lvl != SPEED_MAX) ? lvl + 3'd1 :
               (dec && !inc && lvl != SPEED_MIN) ? lvl - 3'd1 : lvl;
    endfunction

endpackage

// File: rtl/control_input_decoder_button.sv
// button_debouncer: 2-flop synchroniser, debounce counter, debounced level and press pulse
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          diff, done;

    always_comb begin
        sync_d   = {sync_q[0], btn};
        diff     = sync_q[1] ^ stable_q;
        done     = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d    = (diff && !done) ? cnt_q + 1'b1 : '0;
        stable_d = done ? sync_q[1] : stable_q;
        prev_d   = stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

    assign stable = stable_q;
    assign press  = stable_q & ~prev_q;

endmodule

// File: rtl/control_input_decoder.sv
// control_input_decoder: debounced buttons to saturating speed level and pause/resume pulses
// Define AUTO_REPEAT_EN to repeat up/down presses every REPEAT_CYCLES while held.
module control_input_decoder
    import control_input_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REPEAT_CYCLES   = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic [7:0] speed,
    output logic       pause,
    output logic       resume
);

    logic [2:0] btn_raw, lvl_s, press_s;
    logic       inc, dec, unused_sig;

    assign btn_raw = {btn_pause, btn_down, btn_up};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn    (btn_raw[g]),
            .stable (lvl_s[g]),
            .press  (press_s[g])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep_q, rep_d;
    logic          hold_one, rep_fire;

    // Restarting on each press makes the first repeat land a full period after it.
    always_comb begin
        hold_one = lvl_s[0] ^ lvl_s[1];
        rep_fire = hold_one && rep_q == RW'(REPEAT_CYCLES - 1);
        rep_d    = (!hold_one || press_s[0] || press_s[1] || rep_fire) ? '0 : rep_q + 1'b1;
        inc      = press_s[0] | (rep_fire & lvl_s[0]);
        dec      = press_s[1] | (rep_fire & lvl_s[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end

    assign unused_sig = lvl_s[2];
`else
    assign inc        = press_s[0];
    assign dec        = press_s[1];
    assign unused_sig = ^{lvl_s, REPEAT_CYCLES > 0};
`endif

    pause_state_e state_q, state_d;
    logic [2:0]   level_q, level_d;
    logic         pause_q, pause_d, resume_q, resume_d;

    always_comb begin
        level_d  = next_level(level_q, inc, dec);
        pause_d  = press_s[2] && state_q == ST_RUN;
        resume_d = press_s[2] && state_q == ST_PAUSED;
        state_d  = press_s[2] ? (state_q == ST_RUN ? ST_PAUSED : ST_RUN) : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            level_q  <= SPEED_DEFAULT;
            pause_q  <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            pause_q  <= pause_d;
            resume_q <= resume_d;
        end
    end

    assign speed  = {5'b0, level_q};
    assign pause  = pause_q;
    assign resume = resume_q;

endmodule
